pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Hazard controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Decides D-stage stall, E-register bubble insertion and D-stage forwarding selects using Tuse/Tnew comparison.
- Owns the multi-cycle mult/div busy counter, which stalls MDU-accessing instructions in D.
- Drives the enable of the PC and D register, the clear of the E register, and the D-stage comparator forwarding muxes.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu enters E.
- DIV_CYC, 10, busy cycles after a div/divu enters E.
- CNT_W, 4, width of the MDU busy counter; must satisfy 2^CNT_W > max(MULT_CYC, DIV_CYC).

Ports:
- phc_clk_i  in  1  pipeline clock, rising edge.
- phc_rst_i  in  1  asynchronous, active-high reset.
- phc_rs_D_i  in  5  rs address of the instruction in D.
- phc_rt_D_i  in  5  rt address of the instruction in D.
- phc_tuse_rs_D_i  in  2  Tuse for rs: 0, 1 or 2; 3 means not used.
- phc_tuse_rt_D_i  in  2  Tuse for rt; same encoding as rs.
- phc_md_D_i  in  1  D instruction accesses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
- phc_a3_E_i  in  5  destination register of the E instruction; 0 means none.
- phc_tnew_E_i  in  2  cycles until the E result is available.
- phc_a3_M_i  in  5  destination register of the M instruction.
- phc_tnew_M_i  in  2  cycles until the M result is available.
- phc_a3_W_i  in  5  destination register of the W instruction.
- phc_mdstart_E_i  in  1  mult/div is in E this cycle.
- phc_mdop_E_i  in  1  0 = mult/multu, 1 = div/divu.
- phc_stall_o  out  1  freeze PC and D register.
- phc_clr_E_o  out  1  synchronous clear of the E register (bubble).
- phc_mdbusy_o  out  1  MDU counter nonzero.
- phc_fwd_rs_D_o  out  2  rs forwarding select: 0 = regfile, 1 = E, 2 = M, 3 = W.
- phc_fwd_rt_D_o  out  2  rt forwarding select; same encoding as rs.

Behaviour:
- Clock and reset: one clock, phc_clk_i. Reset phc_rst_i is asynchronous and active-high.
- During reset: cnt=0. All outputs are 0: stall_o=0, clr_E_o=0, mdbusy_o=0, fwd selects=0.
- Data hazard for rs: rs_D!=0 and any of:
  - rs_D==a3_E and tuse_rs<tnew_E;
  - rs_D==a3_M and tuse_rs<tnew_M.
  - Tuse=3 never stalls. rt uses the same rule.
- MDU hazard: md_D_i and (mdbusy_o or mdstart_E_i).
- stall_o = data hazard or MDU hazard (combinational, same cycle). clr_E_o = stall_o.
- MDU counter:
  - Async reset to 0.
  - On an edge with mdstart_E_i=1, load MULT_CYC or DIV_CYC per mdop_E_i.
  - Otherwise decrement if nonzero; hold at 0 (no wrap).
  - mdbusy_o = (cnt!=0), registered-derived. Asserted for exactly N cycles after the start cycle.
  - The start cycle itself is covered by mdstart_E_i in the stall equation.
- Simultaneous mdstart_E_i with cnt!=0 (unreachable in legal flow): reload takes priority over decrement.
- Reset asserted mid-count: counter drops to 0 immediately; no residual stall.
- Forwarding select per operand, priority E > M > W:
  - E (1) when addr==a3_E and tnew_E==0.
  - else M (2) when addr==a3_M and tnew_M==0.
  - else W (3) when addr==a3_W.
  - else 0.
  - Address 0 always selects 0.
  - Forwarding selects are valid irrespective of stall; datapath ignores them while stalled.
- Latency: all hazard and forwarding outputs are combinational from inputs and cnt. No added pipeline delay.

Optional Feature:
- PHC_PERF_CNT_EN defined:
  - Adds outputs phc_stallcnt_o[31:0] and phc_mdstallcnt_o[31:0].
  - phc_stallcnt_o increments on each clock edge with stall_o=1.
  - phc_mdstallcnt_o increments only on edges where the MDU hazard is the sole stall cause.
  - Both wrap at 2^32. Async reset to 0.
- Not defined: ports and counters absent; remaining behaviour identical.

Decomposition:
- Package phc_pkg holds:
  - FWD_RF=0, FWD_E=1, FWD_M=2, FWD_W=3;
  - TUSE_NONE=3;
  - MDOP_MULT=0, MDOP_DIV=1;
  - the 2-bit fwd_sel_t typedef.
- One natural sub-module: phc_md_busy, containing the counter, load/decrement and mdbusy_o.
- Hazard and forwarding logic stay in the top module, instantiated once per operand via a shared function.

Test Plan:
- Load-use: E has lw with a3_E=8, tnew_E=2; D has rs=8, tuse_rs=1 -> stall_o=1, clr_E_o=1. Next cycle, with lw in M (tnew_M=1), a3_M=8 and tnew_E=0 from the bubble -> stall_o=0, fwd_rs_D_o=0 until M has tnew_M=0, then fwd_rs_D_o=2.
- Branch on ALU result: E addu a3_E=5, tnew_E=1; D beq rs=5, tuse=0 -> stall 1 cycle. Then a3_M=5, tnew_M=0 -> stall_o=0, fwd_rs_D_o=2.
- $0 immunity: a3_E=0, rs_D=0, tnew_E=2, tuse=0 -> stall_o=0, fwd=0.
- Div busy: mdstart_E_i=1, mdop=1 at cycle t -> mdbusy_o high cycles t+1..t+10, low at t+11. mfhi in D (md_D_i=1) is stalled cycles t..t+10 and released at t+11.
- Reset mid-mult: mult starts, assert phc_rst_i after 2 cycles -> cnt=0, mdbusy_o=0 and stall_o=0 asynchronously. After release, md_D_i=1 alone gives no stall.
- PHC_PERF_CNT_EN: run the div scenario with mfhi waiting -> phc_mdstallcnt_o=11, phc_stallcnt_o=11.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants, select type and hazard/forwarding helpers for the pipeline hazard controller.
package phc_pkg;

  localparam int unsigned REG_AW = 5;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'd0;
  localparam fwd_sel_t FWD_E  = 2'd1;
  localparam fwd_sel_t FWD_M  = 2'd2;
  localparam fwd_sel_t FWD_W  = 2'd3;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic MDOP_MULT = 1'b0;
  localparam logic MDOP_DIV  = 1'b1;

  // Operand needs a value that an in-flight producer cannot supply before its Tuse.
  function automatic logic data_hazard(
    input logic [REG_AW-1:0] addr,
    input logic [1:0]        tuse,
    input logic [REG_AW-1:0] a3_e,
    input logic [1:0]        tnew_e,
    input logic [REG_AW-1:0] a3_m,
    input logic [1:0]        tnew_m
  );
    logic hz;
    hz = 1'b0;
    if (addr != '0 && tuse != TUSE_NONE) begin
      if (addr == a3_e && tuse < tnew_e) hz = 1'b1;
      if (addr == a3_m && tuse < tnew_m) hz = 1'b1;
    end
    return hz;
  endfunction

  // Youngest ready producer wins; $0 is never forwarded.
  function automatic fwd_sel_t fwd_select(
    input logic [REG_AW-1:0] addr,
    input logic [REG_AW-1:0] a3_e,
    input logic [1:0]        tnew_e,
    input logic [REG_AW-1:0] a3_m,
    input logic [1:0]        tnew_m,
    input logic [REG_AW-1:0] a3_w
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (addr != '0) begin
      if (addr == a3_e && tnew_e == 2'd0)      sel = FWD_E;
      else if (addr == a3_m && tnew_m == 2'd0) sel = FWD_M;
      else if (addr == a3_w)                   sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy.sv
// Multiply/divide busy counter: loads the op latency when an MDU op enters E, then counts down to 0.
module phc_md_busy
  import phc_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic phc_clk_i,
  input  logic phc_rst_i,
  input  logic md_start,
  input  logic md_op,
  output logic md_busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] load_val;

  assign load_val = (md_op == MDOP_DIV) ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);

  // A new start reloads even if the previous op has not drained.
  always_ff @(posedge phc_clk_i or posedge phc_rst_i) begin
    if (phc_rst_i) begin
      cnt_q <= '0;
    end else if (md_start) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign md_busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// D-stage hazard controller: stall/bubble decision, D-stage forwarding selects and MDU busy tracking.
// Optional PHC_PERF_CNT_EN adds free-running stall event counters.
module pipe_hazard_ctrl
  import phc_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              phc_clk_i,
  input  logic              phc_rst_i,
  input  logic [REG_AW-1:0] phc_rs_D_i,
  input  logic [REG_AW-1:0] phc_rt_D_i,
  input  logic [1:0]        phc_tuse_rs_D_i,
  input  logic [1:0]        phc_tuse_rt_D_i,
  input  logic              phc_md_D_i,
  input  logic [REG_AW-1:0] phc_a3_E_i,
  input  logic [1:0]        phc_tnew_E_i,
  input  logic [REG_AW-1:0] phc_a3_M_i,
  input  logic [1:0]        phc_tnew_M_i,
  input  logic [REG_AW-1:0] phc_a3_W_i,
  input  logic              phc_mdstart_E_i,
  input  logic              phc_mdop_E_i,
  output logic              phc_stall_o,
  output logic              phc_clr_E_o,
  output logic              phc_mdbusy_o,
  output fwd_sel_t          phc_fwd_rs_D_o,
  output fwd_sel_t          phc_fwd_rt_D_o
`ifdef PHC_PERF_CNT_EN
  ,
  output logic [31:0]       phc_stallcnt_o,
  output logic [31:0]       phc_mdstallcnt_o
`endif
);

  logic md_busy;
  logic hz_rs;
  logic hz_rt;
  logic hz_data;
  logic hz_md;
  logic stall;

  phc_md_busy #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_busy (
    .phc_clk_i (phc_clk_i),
    .phc_rst_i (phc_rst_i),
    .md_start  (phc_mdstart_E_i),
    .md_op     (phc_mdop_E_i),
    .md_busy   (md_busy)
  );

  assign hz_rs = data_hazard(phc_rs_D_i, phc_tuse_rs_D_i, phc_a3_E_i, phc_tnew_E_i,
                             phc_a3_M_i, phc_tnew_M_i);
  assign hz_rt = data_hazard(phc_rt_D_i, phc_tuse_rt_D_i, phc_a3_E_i, phc_tnew_E_i,
                             phc_a3_M_i, phc_tnew_M_i);
  assign hz_data = hz_rs | hz_rt;

  // The start cycle itself is covered by mdstart since the counter loads on that edge.
  assign hz_md = phc_md_D_i & (md_busy | phc_mdstart_E_i);

  // Outputs are forced quiet while reset is held.
  assign stall          = ~phc_rst_i & (hz_data | hz_md);
  assign phc_stall_o    = stall;
  assign phc_clr_E_o    = stall;
  assign phc_mdbusy_o   = md_busy;
  assign phc_fwd_rs_D_o = phc_rst_i ? FWD_RF
                        : fwd_select(phc_rs_D_i, phc_a3_E_i, phc_tnew_E_i,
                                     phc_a3_M_i, phc_tnew_M_i, phc_a3_W_i);
  assign phc_fwd_rt_D_o = phc_rst_i ? FWD_RF
                        : fwd_select(phc_rt_D_i, phc_a3_E_i, phc_tnew_E_i,
                                     phc_a3_M_i, phc_tnew_M_i, phc_a3_W_i);

`ifdef PHC_PERF_CNT_EN
  logic [31:0] stallcnt_q;
  logic [31:0] mdstallcnt_q;

  // MDU-only count excludes cycles where a data hazard would have stalled anyway.
  always_ff @(posedge phc_clk_i or posedge phc_rst_i) begin
    if (phc_rst_i) begin
      stallcnt_q   <= '0;
      mdstallcnt_q <= '0;
    end else begin
      if (stall)             stallcnt_q   <= stallcnt_q + 32'd1;
      if (hz_md && !hz_data) mdstallcnt_q <= mdstallcnt_q + 32'd1;
    end
  end

  assign phc_stallcnt_o   = stallcnt_q;
  assign phc_mdstallcnt_o = mdstallcnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed pipeline scenarios followed by random traffic vs a rule-level model.
module tb_pipe_hazard_ctrl;
  import phc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs, rt, a3_e, a3_m, a3_w;
  logic [1:0] tuse_rs, tuse_rt, tnew_e, tnew_m;
  logic       md_d, md_start, md_op;
  logic       stall, clr_e, mdbusy;
  fwd_sel_t   fwd_rs, fwd_rt;
`ifdef PHC_PERF_CNT_EN
  logic [31:0] stallcnt, mdstallcnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: the MDU is busy in every cycle index up to busy_end.
  int          cyc      = 0;
  int          busy_end = -1;
  int          exp_stall;
  int          exp_md_only;
  logic [31:0] exp_sc  = '0;
  logic [31:0] exp_msc = '0;

  pipe_hazard_ctrl dut (
    .phc_clk_i       (clk),
    .phc_rst_i       (rst),
    .phc_rs_D_i      (rs),
    .phc_rt_D_i      (rt),
    .phc_tuse_rs_D_i (tuse_rs),
    .phc_tuse_rt_D_i (tuse_rt),
    .phc_md_D_i      (md_d),
    .phc_a3_E_i      (a3_e),
    .phc_tnew_E_i    (tnew_e),
    .phc_a3_M_i      (a3_m),
    .phc_tnew_M_i    (tnew_m),
    .phc_a3_W_i      (a3_w),
    .phc_mdstart_E_i (md_start),
    .phc_mdop_E_i    (md_op),
    .phc_stall_o     (stall),
    .phc_clr_E_o     (clr_e),
    .phc_mdbusy_o    (mdbusy),
    .phc_fwd_rs_D_o  (fwd_rs),
    .phc_fwd_rt_D_o  (fwd_rt)
`ifdef PHC_PERF_CNT_EN
    ,
    .phc_stallcnt_o   (stallcnt),
    .phc_mdstallcnt_o (mdstallcnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int m_hazard(int addr, int tuse, int ae, int te, int am, int tm);
    if (addr == 0 || tuse == 3) return 0;
    return ((addr == ae && tuse < te) || (addr == am && tuse < tm)) ? 1 : 0;
  endfunction

  function automatic int m_fwd(int addr, int ae, int te, int am, int tm, int aw);
    if (addr == 0)             return 0;
    if (addr == ae && te == 0) return 1;
    if (addr == am && tm == 0) return 2;
    if (addr == aw)            return 3;
    return 0;
  endfunction

  // Let inputs settle, then compare every output with the model.
  task automatic settle_check();
    int busy, hz_data, hz_md;
    #1;
    busy    = (!rst && cyc <= busy_end) ? 1 : 0;
    hz_data = m_hazard(rs, tuse_rs, a3_e, tnew_e, a3_m, tnew_m) |
              m_hazard(rt, tuse_rt, a3_e, tnew_e, a3_m, tnew_m);
    hz_md   = (md_d && (busy || md_start)) ? 1 : 0;
    exp_stall   = (!rst && (hz_data || hz_md)) ? 1 : 0;
    exp_md_only = (!rst && hz_md && !hz_data) ? 1 : 0;
    if (rst) begin
      exp_sc  = '0;
      exp_msc = '0;
    end
    check("stall",  stall,  exp_stall);
    check("clr_E",  clr_e,  exp_stall);
    check("mdbusy", mdbusy, busy);
    check("fwd_rs", fwd_rs, rst ? 0 : m_fwd(rs, a3_e, tnew_e, a3_m, tnew_m, a3_w));
    check("fwd_rt", fwd_rt, rst ? 0 : m_fwd(rt, a3_e, tnew_e, a3_m, tnew_m, a3_w));
`ifdef PHC_PERF_CNT_EN
    check("stallcnt",   stallcnt,   exp_sc);
    check("mdstallcnt", mdstallcnt, exp_msc);
`endif
  endtask

  // Advance one clock and apply the edge to the model.
  task automatic adv();
    @(posedge clk);
    if (rst) begin
      busy_end = -1;
    end else begin
      if (md_start) busy_end = cyc + (md_op ? 10 : 5);
      if (exp_stall != 0)   exp_sc  = exp_sc + 32'd1;
      if (exp_md_only != 0) exp_msc = exp_msc + 32'd1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs = 0; rt = 0; tuse_rs = 3; tuse_rt = 3; md_d = 0;
    a3_e = 0; tnew_e = 0; a3_m = 0; tnew_m = 0; a3_w = 0;
    md_start = 0; md_op = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    // Reset with hazard-provoking inputs: everything must stay quiet.
    rs = 8; tuse_rs = 0; a3_e = 8; tnew_e = 2; a3_w = 8; md_d = 1; md_start = 1;
    settle_check();
    check("rst_stall", stall, 0);
    check("rst_fwd",   fwd_rs, 0);
    adv();
    adv();
    rst = 1'b0;
    idle_inputs();

    // Load-use: lw in E, consumer with Tuse=1 in D.
    rs = 8; tuse_rs = 1; a3_e = 8; tnew_e = 2;
    settle_check();
    check("lu_stall", stall, 1);
    check("lu_clr",   clr_e, 1);
    adv();
    a3_e = 0; tnew_e = 0; a3_m = 8; tnew_m = 1;
    settle_check();
    check("lu_rel_stall", stall, 0);
    check("lu_rel_fwd",   fwd_rs, 0);
    adv();
    tnew_m = 0;
    settle_check();
    check("lu_fwd_m", fwd_rs, 2);
    adv();

    // Branch on an ALU result still in E.
    idle_inputs();
    rs = 5; tuse_rs = 0; a3_e = 5; tnew_e = 1;
    settle_check();
    check("br_stall", stall, 1);
    adv();
    a3_e = 0; a3_m = 5; tnew_m = 0;
    settle_check();
    check("br_rel", stall, 0);
    check("br_fwd", fwd_rs, 2);
    adv();

    // $0 is never a hazard or forwarding source.
    idle_inputs();
    rs = 0; tuse_rs = 0; a3_e = 0; tnew_e = 2;
    settle_check();
    check("zero_stall", stall, 0);
    check("zero_fwd",   fwd_rs, 0);
    adv();

    // Clear counters, then a div with mfhi waiting in D.
    rst = 1'b1;
    settle_check();
    adv();
    rst = 1'b0;
    idle_inputs();
    md_d = 1; md_start = 1; md_op = MDOP_DIV;
    settle_check();
    check("div_t_stall", stall, 1);
    check("div_t_busy",  mdbusy, 0);
    adv();
    md_start = 0; md_op = 0;
    for (int i = 1; i <= 10; i++) begin
      settle_check();
      check("div_busy",  mdbusy, 1);
      check("div_stall", stall, 1);
      adv();
    end
    settle_check();
    check("div_done_busy",  mdbusy, 0);
    check("div_done_stall", stall, 0);
`ifdef PHC_PERF_CNT_EN
    check("div_stallcnt",   stallcnt, 11);
    check("div_mdstallcnt", mdstallcnt, 11);
`endif
    adv();

    // Reset asserted in the middle of a mult.
    idle_inputs();
    md_start = 1; md_op = MDOP_MULT;
    settle_check();
    adv();
    md_start = 0;
    settle_check();
    adv();
    md_d = 1;
    settle_check();
    check("mul_mid_stall", stall, 1);
    rst = 1'b1;
    settle_check();
    check("mul_rst_busy",  mdbusy, 0);
    check("mul_rst_stall", stall, 0);
    adv();
    rst = 1'b0;
    settle_check();
    check("mul_post_stall", stall, 0);
    adv();

    // Random traffic with a small register set so addresses collide often.
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      rs       = 5'($urandom_range(0, 3));
      rt       = 5'($urandom_range(0, 3));
      tuse_rs  = 2'($urandom_range(0, 3));
      tuse_rt  = 2'($urandom_range(0, 3));
      a3_e     = 5'($urandom_range(0, 3));
      a3_m     = 5'($urandom_range(0, 3));
      a3_w     = 5'($urandom_range(0, 3));
      tnew_e   = 2'($urandom_range(0, 3));
      tnew_m   = 2'($urandom_range(0, 3));
      md_d     = ($urandom_range(0, 2) == 0);
      md_start = ($urandom_range(0, 11) == 0);
      md_op    = 1'($urandom_range(0, 1));
      settle_check();
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
